// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage
// Purpose: IF/ID record type, bubble encoding and the bubble() constructor.
// Ports: none (package).
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [1:0]  BHT_WEAK_NT = 2'b01;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
    logic [1:0]  state;
    logic        prediction_made;
    logic        jalr_addr_req;
  } if_id_t;

  // Inert decode slot: no valid bit and no prediction metadata, so nothing
  // downstream (BHT/BTB update, jalr resolution) can fire from it.
  function automatic if_id_t bubble(input logic [31:0] nop);
    if_id_t b;
    b.pc              = 32'h0000_0000;
    b.pc_plus4        = 32'h0000_0004;
    b.instr           = nop;
    b.valid           = 1'b0;
    b.state           = BHT_WEAK_NT;
    b.prediction_made = 1'b0;
    b.jalr_addr_req   = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - wrapping event counter
// Purpose: counts clock edges on which inc is high; wraps modulo 2^W.
// Ports: clk, reset (sync, active-high), inc (event strobe), count (value).
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - fetch PC register and IF/ID pipeline register
// Purpose: holds pc_f, latches the fetched instruction plus predictor metadata
//   into decode, bubbles on execute redirects, holds on hazard stalls.
// Ports: clk, reset (sync, active-high); target_pc, instr_f, state_f,
//   prediction_made_f, jalr_addr_req_f from fetch/predictor; stall_i, flush_i
//   control; pc_f to imem/predictor; *_d decode-side fields; fetch_count and
//   flush_count performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      target_pc,
  input  logic [31:0]      instr_f,
  input  logic [1:0]       state_f,
  input  logic             prediction_made_f,
  input  logic             jalr_addr_req_f,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [31:0]      pc_f,
  output logic [31:0]      pc_d,
  output logic [31:0]      pc_plus4_d,
  output logic [31:0]      instr_d,
  output logic             valid_d,
  output logic [1:0]       state_d,
  output logic             prediction_made_d,
  output logic             jalr_addr_req_d,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] flush_count
);

  import fetch_pkg::*;

  logic [31:0] r_pc;
  if_id_t      r_if_id;
  if_id_t      w_capture;
  logic        w_fetch_inc;

  always_comb begin
    w_capture                 = bubble(NOP_INSTR);
    w_capture.pc              = r_pc;
    w_capture.pc_plus4        = r_pc + 32'd4;
    w_capture.instr           = instr_f;
    w_capture.valid           = 1'b1;
    w_capture.state           = state_f;
    w_capture.prediction_made = prediction_made_f;
    w_capture.jalr_addr_req   = jalr_addr_req_f;
  end

  // Flush outranks stall so an execute redirect is never swallowed by a
  // simultaneous hazard hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (flush_i || !stall_i) begin
      r_pc <= target_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      r_if_id <= bubble(NOP_INSTR);
    end else if (!stall_i) begin
      r_if_id <= w_capture;
    end
  end

  assign w_fetch_inc = !flush_i && !stall_i;

  perf_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_fetch_inc),
    .count (fetch_count)
  );

  perf_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_i),
    .count (flush_count)
  );

  assign pc_f              = r_pc;
  assign pc_d              = r_if_id.pc;
  assign pc_plus4_d        = r_if_id.pc_plus4;
  assign instr_d           = r_if_id.instr;
  assign valid_d           = r_if_id.valid;
  assign state_d           = r_if_id.state;
  assign prediction_made_d = r_if_id.prediction_made;
  assign jalr_addr_req_d   = r_if_id.jalr_addr_req;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] target_pc;
  logic [31:0] instr_f;
  logic [1:0]  state_f;
  logic        prediction_made_f;
  logic        jalr_addr_req_f;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] pc_f, pc_d, pc_plus4_d, instr_d;
  logic        valid_d;
  logic [1:0]  state_d;
  logic        prediction_made_d, jalr_addr_req_d;
  logic [31:0] fetch_count, flush_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk               (clk),
    .reset             (reset),
    .target_pc         (target_pc),
    .instr_f           (instr_f),
    .state_f           (state_f),
    .prediction_made_f (prediction_made_f),
    .jalr_addr_req_f   (jalr_addr_req_f),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .pc_f              (pc_f),
    .pc_d              (pc_d),
    .pc_plus4_d        (pc_plus4_d),
    .instr_d           (instr_d),
    .valid_d           (valid_d),
    .state_d           (state_d),
    .prediction_made_d (prediction_made_d),
    .jalr_addr_req_d   (jalr_addr_req_d),
    .fetch_count       (fetch_count),
    .flush_count       (flush_count)
  );

  typedef struct {
    logic        rst, fl, st;
    logic [31:0] tgt, ins;
    logic [1:0]  sf;
    logic        pm, jr;
    logic [31:0] e_pc, e_pcd, e_p4, e_ins;
    logic        e_v;
    logic [1:0]  e_st;
    logic        e_pm, e_jr;
    logic [31:0] e_fc, e_flc;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst, fl, st, input logic [31:0] tgt, ins,
                         input logic [1:0] sf, input logic pm, jr,
                         input logic [31:0] e_pc, e_pcd, e_p4, e_ins,
                         input logic e_v, input logic [1:0] e_st,
                         input logic e_pm, e_jr, input logic [31:0] e_fc, e_flc);
    vec_t v;
    v.rst = rst; v.fl = fl; v.st = st; v.tgt = tgt; v.ins = ins;
    v.sf = sf; v.pm = pm; v.jr = jr;
    v.e_pc = e_pc; v.e_pcd = e_pcd; v.e_p4 = e_p4; v.e_ins = e_ins;
    v.e_v = e_v; v.e_st = e_st; v.e_pm = e_pm; v.e_jr = e_jr;
    v.e_fc = e_fc; v.e_flc = e_flc;
    vecs.push_back(v);
  endtask

  // Same as add_vec but with the decode slot expected to be a bubble.
  task automatic add_bub(input logic rst, fl, st, input logic [31:0] tgt, ins,
                         input logic [1:0] sf, input logic pm, jr,
                         input logic [31:0] e_pc, e_fc, e_flc);
    add_vec(rst, fl, st, tgt, ins, sf, pm, jr,
            e_pc, 32'h0, 32'h4, 32'h13, 1'b0, 2'b01, 1'b0, 1'b0, e_fc, e_flc);
  endtask

  function automatic logic [196:0] actual();
    return {pc_f, pc_d, pc_plus4_d, instr_d, valid_d, state_d,
            prediction_made_d, jalr_addr_req_d, fetch_count, flush_count};
  endfunction

  task automatic drive(input logic rst, fl, st, input logic [31:0] tgt, ins,
                       input logic [1:0] sf, input logic pm, jr);
    reset = rst; flush_i = fl; stall_i = st; target_pc = tgt; instr_f = ins;
    state_f = sf; prediction_made_f = pm; jalr_addr_req_f = jr;
  endtask

  task automatic check(input string name, input logic [196:0] exp);
    logic [196:0] act;
    act = actual();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {pc_f,pc_d,p4,instr,v,st,pm,jr,fc,flc}=%h want %h", name, act, exp);
    end
  endtask

  // Reference model: the decode slot is either the last accepted fetch or
  // an inert bubble; the PC follows target_pc unless held by a lone stall.
  logic [31:0] m_pc, m_pcd, m_p4, m_ins, m_fc, m_flc;
  logic        m_v, m_pm, m_jr;
  logic [1:0]  m_st;

  task automatic model_bubble();
    m_pcd = 32'h0; m_p4 = 32'h4; m_ins = 32'h13; m_v = 1'b0;
    m_st = 2'b01; m_pm = 1'b0; m_jr = 1'b0;
  endtask

  task automatic model_step(input logic rst, fl, st, input logic [31:0] tgt, ins,
                            input logic [1:0] sf, input logic pm, jr);
    if (rst) begin
      m_pc = 32'h0; m_fc = 0; m_flc = 0; model_bubble();
    end else if (fl) begin
      model_bubble(); m_pc = tgt; m_flc = m_flc + 1;
    end else if (!st) begin
      m_pcd = m_pc; m_p4 = m_pc + 32'd4; m_ins = ins; m_v = 1'b1;
      m_st = sf; m_pm = pm; m_jr = jr;
      m_pc = tgt; m_fc = m_fc + 1;
    end
  endtask

  initial begin
    // Test-plan sequence: release, stall, flush, flush+stall, wrap, reset-in-stall.
    add_bub(1,0,0, 32'h4,        32'h00500093, 2'b10, 0,0, 32'h0, 0, 0);
    add_vec(0,0,0, 32'h4,        32'h00500093, 2'b10, 0,0,
            32'h4, 32'h0, 32'h4, 32'h00500093, 1, 2'b10, 0,0, 1, 0);
    add_vec(0,0,0, 32'h8,        32'h11111111, 2'b00, 0,0,
            32'h8, 32'h4, 32'h8, 32'h11111111, 1, 2'b00, 0,0, 2, 0);
    for (int i = 0; i < 3; i++)
      add_vec(0,0,1, 32'hC,      32'h22222222, 2'b11, 1,1,
              32'h8, 32'h4, 32'h8, 32'h11111111, 1, 2'b00, 0,0, 2, 0);
    add_vec(0,0,0, 32'hC,        32'h22222222, 2'b11, 0,0,
            32'hC, 32'h8, 32'hC, 32'h22222222, 1, 2'b11, 0,0, 3, 0);
    add_bub(0,1,0, 32'h40,       32'h33333333, 2'b10, 1,0, 32'h40, 3, 1);
    add_vec(0,0,0, 32'h44,       32'h44444444, 2'b10, 1,0,
            32'h44, 32'h40, 32'h44, 32'h44444444, 1, 2'b10, 1,0, 4, 1);
    add_bub(0,1,1, 32'h100,      32'h99999999, 2'b11, 1,1, 32'h100, 4, 2);
    add_vec(0,0,0, 32'hFFFFFFFC, 32'h55555555, 2'b01, 0,0,
            32'hFFFFFFFC, 32'h100, 32'h104, 32'h55555555, 1, 2'b01, 0,0, 5, 2);
    add_vec(0,0,0, 32'h0,        32'h66666666, 2'b11, 0,1,
            32'h0, 32'hFFFFFFFC, 32'h0, 32'h66666666, 1, 2'b11, 0,1, 6, 2);
    add_vec(0,0,0, 32'h20,       32'h77777777, 2'b00, 0,0,
            32'h20, 32'h0, 32'h4, 32'h77777777, 1, 2'b00, 0,0, 7, 2);
    add_vec(0,0,1, 32'h24,       32'hAAAAAAAA, 2'b10, 1,1,
            32'h20, 32'h0, 32'h4, 32'h77777777, 1, 2'b00, 0,0, 7, 2);
    add_bub(1,1,1, 32'h24,       32'hAAAAAAAA, 2'b10, 1,1, 32'h0, 0, 0);
    add_vec(0,0,0, 32'h8,        32'h88888888, 2'b10, 0,0,
            32'h8, 32'h0, 32'h4, 32'h88888888, 1, 2'b10, 0,0, 1, 0);
    // Back-to-back flushes: one bubble and one count per cycle.
    add_bub(0,1,0, 32'h200,      32'hBBBBBBBB, 2'b11, 1,1, 32'h200, 1, 1);
    add_bub(0,1,0, 32'h300,      32'hCCCCCCCC, 2'b11, 1,1, 32'h300, 1, 2);
    add_vec(0,0,0, 32'h304,      32'hDDDDDDDD, 2'b01, 0,1,
            32'h304, 32'h300, 32'h304, 32'hDDDDDDDD, 1, 2'b01, 0,1, 2, 2);

    drive(1,0,0, 32'h0, 32'h0, 2'b00, 0,0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].st, vecs[i].tgt, vecs[i].ins,
            vecs[i].sf, vecs[i].pm, vecs[i].jr);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i),
            {vecs[i].e_pc, vecs[i].e_pcd, vecs[i].e_p4, vecs[i].e_ins, vecs[i].e_v,
             vecs[i].e_st, vecs[i].e_pm, vecs[i].e_jr, vecs[i].e_fc, vecs[i].e_flc});
    end

    // Randomized phase against the reference model; first cycle forces reset.
    for (int c = 0; c < 400; c++) begin
      logic        r_rst, r_fl, r_st, r_pm, r_jr;
      logic [31:0] r_tgt, r_ins;
      logic [1:0]  r_sf;
      r_rst = (c == 0) || ($urandom_range(49) == 0);
      r_fl  = ($urandom_range(4) == 0);
      r_st  = ($urandom_range(3) == 0);
      r_tgt = ($urandom_range(7) == 0) ? 32'hFFFFFFFC : $urandom;
      r_ins = $urandom;
      r_sf  = 2'($urandom_range(3));
      r_pm  = 1'($urandom_range(1));
      r_jr  = 1'($urandom_range(1));
      drive(r_rst, r_fl, r_st, r_tgt, r_ins, r_sf, r_pm, r_jr);
      model_step(r_rst, r_fl, r_st, r_tgt, r_ins, r_sf, r_pm, r_jr);
      @(posedge clk); #1;
      check($sformatf("rand%0d", c),
            {m_pc, m_pcd, m_p4, m_ins, m_v, m_st, m_pm, m_jr, m_fc, m_flc});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
